// File: rtl/multi_decade.sv
// Three-digit synchronous BCD up-counter (000-999) with enable and terminal-count flag.
// Each digit is a decade_stage; carry enables ripple combinationally within one clock domain.

module decade_stage (
    input  logic       clk,
    input  logic       rstn,
    input  logic       inc,
    output logic [3:0] q,
    output logic       at9
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= 4'd0;
        end else if (inc) begin
            // Wrapping on >=9 keeps any stray code from leaving the 0-9 range.
            if (q >= 4'd9) begin
                q <= 4'd0;
            end else begin
                q <= q + 4'd1;
            end
        end
    end

    assign at9 = (q == 4'd9);

endmodule

module multi_decade (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       done
);

    logic inc_ones;
    logic inc_tens;
    logic inc_hundreds;
    logic ones_at9;
    logic tens_at9;
    logic hundreds_at9;

    // A stage advances only when every lower stage sits at 9 on an enabled edge.
    assign inc_ones     = en;
    assign inc_tens     = inc_ones & ones_at9;
    assign inc_hundreds = inc_tens & tens_at9;

    decade_stage u_ones (
        .clk  (clk),
        .rstn (rstn),
        .inc  (inc_ones),
        .q    (ones),
        .at9  (ones_at9)
    );

    decade_stage u_tens (
        .clk  (clk),
        .rstn (rstn),
        .inc  (inc_tens),
        .q    (tens),
        .at9  (tens_at9)
    );

    decade_stage u_hundreds (
        .clk  (clk),
        .rstn (rstn),
        .inc  (inc_hundreds),
        .q    (hundreds),
        .at9  (hundreds_at9)
    );

    // Terminal count decoded straight from the digit registers, independent of en.
    assign done = ones_at9 & tens_at9 & hundreds_at9;

endmodule

// File: tb/tb_multi_decade.sv
// Directed bench for multi_decade: reset, carries, wrap, hold at 999, async reset mid-count.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_multi_decade;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic       done;

    int vec_cnt = 0;
    int err_cnt = 0;
    int done_pulses;

    multi_decade dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .ones     (ones),
        .tens     (tens),
        .hundreds (hundreds),
        .done     (done)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare the three digits as a BCD word and the done flag.
    task automatic check_count(input string tag, input logic [11:0] exp_bcd, input logic exp_done);
        check({tag, ".count"}, {4'h0, hundreds, tens, ones}, {4'h0, exp_bcd});
        check({tag, ".done"}, {15'd0, done}, {15'd0, exp_done});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        en   = 1'b0;
        tick(1);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        en   = 1'b0;

        // 1: asynchronous reset state before any clock edge, then idle with en=0
        #1;
        check_count("reset_t1ns", 12'h000, 1'b0);
        tick(1);
        rstn = 1'b1;
        tick(3);
        check_count("idle_en0", 12'h000, 1'b0);

        // 2: ones rolls into tens
        en = 1'b1;
        tick(9);
        check_count("count_009", 12'h009, 1'b0);
        tick(1);
        check_count("count_010", 12'h010, 1'b0);

        // 3: double carry on one edge
        do_reset();
        en = 1'b1;
        tick(99);
        check_count("count_099", 12'h099, 1'b0);
        tick(1);
        check_count("count_100", 12'h100, 1'b0);

        // 4: full 1000-cycle lap with a single done pulse
        do_reset();
        en = 1'b1;
        done_pulses = 0;
        for (int i = 1; i <= 1000; i++) begin
            tick(1);
            if (done) done_pulses++;
            if (i == 500) check_count("count_500", 12'h500, 1'b0);
            if (i == 998) check_count("count_998", 12'h998, 1'b0);
            if (i == 999) check_count("count_999", 12'h999, 1'b1);
            if (i == 1000) check_count("wrap_000", 12'h000, 1'b0);
        end
        check("done_pulses", done_pulses[15:0], 16'd1);

        // 5: hold at 999 with en low, then wrap on the next enabled edge
        tick(999);
        check_count("reach_999", 12'h999, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_count("hold_999", 12'h999, 1'b1);
        end
        en = 1'b1;
        tick(1);
        check_count("resume_000", 12'h000, 1'b0);
        tick(1);
        check_count("resume_001", 12'h001, 1'b0);

        // 6: asynchronous reset between edges at 457, reset priority over en
        do_reset();
        en = 1'b1;
        tick(457);
        check_count("count_457", 12'h457, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check_count("async_clr", 12'h000, 1'b0);
        tick(1);
        tick(1);
        check_count("rst_over_en", 12'h000, 1'b0);
        rstn = 1'b1;
        tick(1);
        check_count("after_rst_001", 12'h001, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/multi_decade.md
Name: multi_decade

Overview:
Three-digit synchronous BCD up-counter covering 000–999, with an enable input and a terminal-count flag. Each digit is a mod-10 decade stage. A stage advances only when all lower stages are at 9 and the counter is enabled (ripple-carry enables, single clock domain). It is used as a general event/cycle counter with decimal-readable outputs.

Parameters:
none (fixed 3 decades, 4-bit BCD per digit)

Ports:
clk       input   1  system clock; all state updates on rising edge
rstn      input   1  reset; one clock; reset is asynchronous and active-low
en        input   1  count enable; counter advances by 1 on each rising clk edge where en=1
ones      output  4  BCD units digit, 0–9
tens      output  4  BCD tens digit, 0–9
hundreds  output  4  BCD hundreds digit, 0–9
done      output  1  terminal-count flag; high while count = 999

Behaviour:
- Reset: rstn=0 immediately forces ones=tens=hundreds=0, with no clock required. done=0 during reset.
- Reset has priority over en at all times. Reset asserted mid-count clears the counter at once. After rstn rises, counting resumes from 000 on the next enabled edge.
- en=0: all digits hold their value. done reflects the held value.
- en=1, on each rising clk edge, the count increments by exactly 1 in decimal:
  - ones: 0→1→…→9→0.
  - tens increments only on an edge where en=1 and ones=9. tens 9→0 wraps.
  - hundreds increments only on an edge where en=1, ones=9 and tens=9. hundreds 9→0 wraps.
- Wrap-around: 999 with en=1 becomes 000 on the next edge. There is no saturation and no sticky flag.
- done is combinational from the digit registers: done = (hundreds=9 && tens=9 && ones=9). It is independent of en. It is high for exactly one cycle per 1000 enabled cycles during continuous counting, and stays high while held at 999 with en=0.
- Latency: digits update on the same edge that samples en=1. No pipeline stages.
- Digit values never leave 0–9 (no illegal BCD codes 10–15 are ever produced). Any digit reaching 9 wraps to 0 when its increment condition is true.
- Per-digit logic is a reusable decade-counter stage with inputs clk, rstn, inc and outputs q[3:0], at9. Carry enables are chained combinationally. There are no derived or gated clocks.

Test Plan:
1. Hold rstn=0, check 1 ns after start → ones=tens=hundreds=0, done=0. Release rstn with en=0 for 3 cycles → all digits stay 0, done=0.
2. en=1 for 9 cycles → ones=9, tens=0, hundreds=0. One more cycle → ones=0, tens=1.
3. en=1 continuously from reset for 99 cycles → count 099. Next cycle → 100 (both carries ripple on one edge).
4. en=1 for 999 cycles → 999 with done=1. Next cycle → 000, done=0. Total 1000 cycles returns to 000, with done high exactly one cycle.
5. Reach 999 with en=1, then drop en=0 for 5 cycles → holds 999 and done stays 1. Raise en → 000 on the next edge.
6. Count to 457, then assert rstn=0 between clock edges → digits read 000 immediately (asynchronous). Release rstn with en=1 → 001 after the first edge.
